ecc_apb_sequencer: RTL and testbench

- Upstream stage of the ECC encoder/decoder. Turns one high-level job request into the APB register-write sequence that programs and starts the ECC block.
- Job fields: operation, data, codeword width, noise.
- After starting the job it waits for operation_done, captures data_out and num_of_errors, and returns them on a valid/ready response port.
- Acts as the stimulus-side APB master in both the block-level bench and the top-level bench.

---
 rtl/ecc_apb_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: turns one ECC job request into the APB write sequence
// (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL), waits for completion and returns the result.
module ecc_apb_sequencer #(
    parameter int unsigned                  AMBA_ADDR_WIDTH = 32,
    parameter int unsigned                  AMBA_WORD       = 32,
    parameter int unsigned                  DATA_WIDTH      = 32,
    parameter int unsigned                  TIMEOUT_CYCLES  = 1024,
    parameter logic [AMBA_ADDR_WIDTH-1:0]   BASE_ADDR       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [1:0]                 req_width,
    input  logic [DATA_WIDTH-1:0]      req_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_num_errors,
    output logic                       rsp_timeout
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0]  IDX_CTRL = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t                     r_state, w_state_nxt;
    logic [1:0]                 r_idx, w_idx_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [1:0]                 r_op, w_op_nxt;
    logic [DATA_WIDTH-1:0]      r_data, w_data_nxt;
    logic [1:0]                 r_width, w_width_nxt;
    logic [DATA_WIDTH-1:0]      r_noise, w_noise_nxt;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
    logic [AMBA_WORD-1:0]       r_pwdata, w_pwdata_nxt;
    logic                       r_psel, w_psel_nxt;
    logic                       r_penable, w_penable_nxt;
    logic                       r_pwrite, w_pwrite_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]      r_rsp_data, w_rsp_data_nxt;
    logic [1:0]                 r_rsp_nerr, w_rsp_nerr_nxt;
    logic                       r_rsp_timeout, w_rsp_timeout_nxt;
    logic                       w_load;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_op          <= '0;
            r_data        <= '0;
            r_width       <= '0;
            r_noise       <= '0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_nerr    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_op          <= w_op_nxt;
            r_data        <= w_data_nxt;
            r_width       <= w_width_nxt;
            r_noise       <= w_noise_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_nerr    <= w_rsp_nerr_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    // Next state, request latch, APB and response outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_cnt_nxt         = r_cnt;
        w_op_nxt          = r_op;
        w_data_nxt        = r_data;
        w_width_nxt       = r_width;
        w_noise_nxt       = r_noise;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_nerr_nxt    = r_rsp_nerr;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_load            = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_op_nxt    = req_op;
                    w_data_nxt  = req_data;
                    w_width_nxt = req_width;
                    w_noise_nxt = req_noise;
                    if (req_op != 2'd0) begin
                        w_state_nxt = S_SETUP;
                        w_idx_nxt   = 2'd0;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt       = S_RESP;
                        w_rsp_valid_nxt   = 1'b1;
                        w_rsp_data_nxt    = '0;
                        w_rsp_nerr_nxt    = '0;
                        w_rsp_timeout_nxt = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
            end
            S_ACCESS: begin
                if (r_idx == IDX_CTRL) begin
                    w_state_nxt   = S_WAIT;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = 1'b0;
                    w_cnt_nxt     = '0;
                end else begin
                    w_state_nxt = S_SETUP;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_load      = 1'b1;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a coincident timeout
                if (operation_done) begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_data_nxt    = data_out;
                    w_rsp_nerr_nxt    = num_of_errors;
                    w_rsp_timeout_nxt = 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_data_nxt    = '0;
                    w_rsp_nerr_nxt    = '0;
                    w_rsp_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // SETUP phase payload; index 0 comes straight from the request being accepted
        if (w_load) begin
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_pwrite_nxt  = 1'b1;
            unique case (w_idx_nxt)
                2'd0: begin
                    w_paddr_nxt  = BASE_ADDR + AMBA_ADDR_WIDTH'(4);
                    w_pwdata_nxt = AMBA_WORD'(w_data_nxt);
                end
                2'd1: begin
                    w_paddr_nxt  = BASE_ADDR + AMBA_ADDR_WIDTH'(8);
                    w_pwdata_nxt = AMBA_WORD'(w_width_nxt);
                end
                2'd2: begin
                    w_paddr_nxt  = BASE_ADDR + AMBA_ADDR_WIDTH'(12);
                    w_pwdata_nxt = AMBA_WORD'(w_noise_nxt);
                end
                default: begin
                    w_paddr_nxt  = BASE_ADDR;
                    w_pwdata_nxt = AMBA_WORD'(w_op_nxt - 2'd1);
                end
            endcase
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign paddr          = r_paddr;
    assign pwdata         = r_pwdata;
    assign psel           = r_psel;
    assign penable        = r_penable;
    assign pwrite         = r_pwrite;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_num_errors = r_rsp_nerr;
    assign rsp_timeout    = r_rsp_timeout;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: directed bench for ecc_apb_sequencer with hand-computed
// APB write sequences and responses (TIMEOUT_CYCLES = 16).
module tb_ecc_apb_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_width = '0;
    logic [31:0] req_noise = '0;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        psel, penable, pwrite;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = '0;
    logic [1:0]  num_of_errors = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_num_errors;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_errors = 0;

    ecc_apb_sequencer #(
        .AMBA_ADDR_WIDTH (32),
        .AMBA_WORD       (32),
        .DATA_WIDTH      (32),
        .TIMEOUT_CYCLES  (16),
        .BASE_ADDR       (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_data       (req_data),
        .req_width      (req_width),
        .req_noise      (req_noise),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .operation_done (operation_done),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_num_errors (rsp_num_errors),
        .rsp_timeout    (rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a job for one accept edge, then scramble the request fields
    task automatic start_job(input logic [1:0] op, input logic [31:0] d,
                             input logic [1:0] w, input logic [31:0] n);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_data = d; req_width = w; req_noise = n;
        chk("req_ready_idle", 96'(req_ready), 96'(1));
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = ~op; req_data = ~d; req_width = ~w; req_noise = ~n;
    endtask

    // One 2-cycle APB write: SETUP then ACCESS
    task automatic expect_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        chk({tag, "_setup"}, {29'd0, psel, penable, pwrite, paddr, pwdata},
                             {29'd0, 1'b1, 1'b0, 1'b1, a, d});
        @(negedge clk);
        chk({tag, "_access"}, {29'd0, psel, penable, pwrite, paddr, pwdata},
                              {29'd0, 1'b1, 1'b1, 1'b1, a, d});
    endtask

    // From the CTRL ACCESS cycle: wait dly cycles, pulse done, check the response
    task automatic done_and_check(input string tag, input int dly, input logic [31:0] dout,
                                  input logic [1:0] nerr);
        @(negedge clk);
        chk({tag, "_wait_idle_bus"}, {93'd0, psel, penable, pwrite}, 96'd0);
        repeat (dly - 1) @(negedge clk);
        operation_done = 1'b1; data_out = dout; num_of_errors = nerr;
        @(negedge clk);
        operation_done = 1'b0; data_out = 32'hDEAD_BEEF; num_of_errors = 2'd3;
        chk({tag, "_rsp"}, {61'd0, rsp_valid, rsp_data, rsp_num_errors, rsp_timeout},
                           {61'd0, 1'b1, dout, nerr, 1'b0});
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_back_idle"}, {94'd0, rsp_valid, req_ready}, {94'd0, 1'b0, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("reset_apb", {29'd0, psel, penable, pwrite, paddr, pwdata}, 96'd0);
        chk("reset_rsp", {57'd0, req_ready, rsp_valid, rsp_data, rsp_num_errors, rsp_timeout},
                         {57'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // Encode
        start_job(2'd1, 32'h0000_00A5, 2'd0, 32'd0);
        expect_wr("enc_data",  32'h04, 32'hA5);
        expect_wr("enc_width", 32'h08, 32'h0);
        expect_wr("enc_noise", 32'h0C, 32'h0);
        expect_wr("enc_ctrl",  32'h00, 32'h0);
        done_and_check("enc", 3, 32'h1A5, 2'd0);
        handshake("enc");

        // Full channel with a stale done pulse during the writes, then backpressure
        start_job(2'd3, 32'h1234_5678, 2'd2, 32'h0000_0004);
        operation_done = 1'b1;
        data_out = 32'h0BAD_0BAD;
        expect_wr("fc_data",  32'h04, 32'h1234_5678);
        operation_done = 1'b0;
        expect_wr("fc_width", 32'h08, 32'h2);
        expect_wr("fc_noise", 32'h0C, 32'h4);
        expect_wr("fc_ctrl",  32'h00, 32'h2);
        done_and_check("fc", 2, 32'h0000_005A, 2'd1);
        req_valid = 1'b1; req_op = 2'd0; req_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {58'd0, req_ready, psel, rsp_valid, rsp_data, rsp_num_errors, rsp_timeout},
                           {58'd0, 1'b0, 1'b0, 1'b1, 32'h5A, 2'd1, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {94'd0, rsp_valid, req_ready}, {94'd0, 1'b0, 1'b1});

        // The pending req_op=0 job is accepted now: no APB traffic, response next cycle
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("nop_rsp", {60'd0, psel, rsp_valid, rsp_data, rsp_num_errors, rsp_timeout},
                       {60'd0, 1'b0, 1'b1, 32'd0, 2'd0, 1'b0});
        handshake("nop");

        // Timeout: decode, done never asserted, 16 WAIT cycles
        data_out = 32'hDEAD_BEEF;
        start_job(2'd2, 32'h0000_0003, 2'd1, 32'd0);
        expect_wr("to_data",  32'h04, 32'h3);
        expect_wr("to_width", 32'h08, 32'h1);
        expect_wr("to_noise", 32'h0C, 32'h0);
        expect_wr("to_ctrl",  32'h00, 32'h1);
        repeat (16) @(negedge clk);
        chk("to_last_wait", {95'd0, rsp_valid}, 96'd0);
        @(negedge clk);
        chk("to_rsp", {61'd0, rsp_valid, rsp_data, rsp_num_errors, rsp_timeout},
                      {61'd0, 1'b1, 32'd0, 2'd0, 1'b1});
        handshake("to");

        // Reset during NOISE ACCESS abandons the job
        start_job(2'd3, 32'h0000_0077, 2'd3, 32'h0000_0009);
        expect_wr("rst_data",  32'h04, 32'h77);
        expect_wr("rst_width", 32'h08, 32'h3);
        expect_wr("rst_noise", 32'h0C, 32'h9);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {92'd0, psel, penable, req_ready, rsp_valid}, {92'd0, 4'b0010});
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_quiet", {92'd0, psel, penable, req_ready, rsp_valid}, {92'd0, 4'b0010});
        end

        // Next job after reset runs normally
        start_job(2'd1, 32'h0000_003C, 2'd1, 32'h0000_0002);
        expect_wr("post_data",  32'h04, 32'h3C);
        expect_wr("post_width", 32'h08, 32'h1);
        expect_wr("post_noise", 32'h0C, 32'h2);
        expect_wr("post_ctrl",  32'h00, 32'h0);
        done_and_check("post", 1, 32'h13C, 2'd2);
        handshake("post");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
